// File: rtl/phy_rx_sync_ctrl.sv
// Two-lane comma lock controller: per-lane SEARCH/LOCKING/ACTIVE FSMs with bit-slip realignment.
// Optional macro PHY_RX_LANE_GATE_EN holds back payload until both lanes are locked.

module phy_rx_sync_lane #(
    parameter logic [7:0] COM_CHAR     = 8'hBC,
    parameter logic [7:0] IDLE_CHAR    = 8'h7C,
    parameter int         COM_COUNT    = 4,
    parameter int         SLIP_TIMEOUT = 8,
    parameter int         SLIP_HOLDOFF = 2
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic       resync,
    input  logic [7:0] byte_in,
    input  logic       byte_vld,
    input  logic       gate_ok,
    output logic       lock_now,
    output logic       payload,
    output logic       bit_slip,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);
    typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} lane_state_t;

    localparam logic [3:0] COM_LAST  = 4'(COM_COUNT - 1);
    localparam logic [7:0] MISS_LAST = 8'(SLIP_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(SLIP_HOLDOFF);

    lane_state_t state;
    logic [3:0]  com_cnt;
    logic [7:0]  miss_cnt;
    logic [7:0]  holdoff_cnt;
    logic        is_com;
    logic        is_idle;

    assign is_com  = (byte_in == COM_CHAR);
    assign is_idle = (byte_in == IDLE_CHAR);

    // Look-ahead flags let the top compute all_active for the same edge as the lane outputs.
    assign lock_now = !resync && byte_vld && (state == LOCKING) && is_com && (com_cnt >= COM_LAST);
    assign payload  = !resync && byte_vld && (state == ACTIVE) && !is_com && !is_idle;

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state       <= SEARCH;
            com_cnt     <= '0;
            miss_cnt    <= '0;
            holdoff_cnt <= '0;
            bit_slip    <= 1'b0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            active      <= 1'b0;
        end else begin
            bit_slip  <= 1'b0;
            valid_out <= 1'b0;
            if (resync) begin
                state       <= SEARCH;
                com_cnt     <= '0;
                miss_cnt    <= '0;
                holdoff_cnt <= '0;
                active      <= 1'b0;
            end else if (byte_vld) begin
                unique case (state)
                    SEARCH: begin
                        // After a slip the deserializer output is unreliable for a few bytes.
                        if (holdoff_cnt != 8'd0) begin
                            holdoff_cnt <= holdoff_cnt - 8'd1;
                        end else if (is_com) begin
                            com_cnt  <= 4'd1;
                            miss_cnt <= '0;
                            state    <= LOCKING;
                        end else if (miss_cnt >= MISS_LAST) begin
                            miss_cnt    <= '0;
                            holdoff_cnt <= HOLD_LOAD;
                            bit_slip    <= 1'b1;
                        end else begin
                            miss_cnt <= miss_cnt + 8'd1;
                        end
                    end
                    LOCKING: begin
                        if (is_com) begin
                            if (com_cnt >= COM_LAST) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end else begin
                                com_cnt <= com_cnt + 4'd1;
                            end
                        end else begin
                            state    <= SEARCH;
                            com_cnt  <= '0;
                            miss_cnt <= '0;
                        end
                    end
                    ACTIVE: begin
                        if (payload && gate_ok) begin
                            data_out  <= byte_in;
                            valid_out <= 1'b1;
                        end
                    end
                    default: begin
                        state <= SEARCH;
                    end
                endcase
            end
        end
    end
endmodule

module phy_rx_sync_ctrl #(
    parameter logic [7:0] COM_CHAR     = 8'hBC,
    parameter logic [7:0] IDLE_CHAR    = 8'h7C,
    parameter int         COM_COUNT    = 4,
    parameter int         SLIP_TIMEOUT = 8,
    parameter int         SLIP_HOLDOFF = 2
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic [7:0] byte_in_0,
    input  logic       byte_vld_0,
    input  logic [7:0] byte_in_1,
    input  logic       byte_vld_1,
    input  logic       resync,
    output logic       bit_slip_0,
    output logic       bit_slip_1,
    output logic [7:0] data_out_0,
    output logic       valid_out_0,
    output logic [7:0] data_out_1,
    output logic       valid_out_1,
    output logic       active_0,
    output logic       active_1,
    output logic       all_active
);
    logic lock_now_0;
    logic lock_now_1;
    logic payload_0;
    logic payload_1;
    logic all_next;
    logic gate_ok;

    // all_active rises on the same edge as the second lane's active, so gating lines up exactly.
    assign all_next = !resync && (active_0 || lock_now_0) && (active_1 || lock_now_1);

`ifdef PHY_RX_LANE_GATE_EN
    assign gate_ok = all_next;
`else
    assign gate_ok = 1'b1;
`endif

    phy_rx_sync_lane #(
        .COM_CHAR    (COM_CHAR),
        .IDLE_CHAR   (IDLE_CHAR),
        .COM_COUNT   (COM_COUNT),
        .SLIP_TIMEOUT(SLIP_TIMEOUT),
        .SLIP_HOLDOFF(SLIP_HOLDOFF)
    ) lane_0 (
        .clk_f    (clk_f),
        .reset    (reset),
        .resync   (resync),
        .byte_in  (byte_in_0),
        .byte_vld (byte_vld_0),
        .gate_ok  (gate_ok),
        .lock_now (lock_now_0),
        .payload  (payload_0),
        .bit_slip (bit_slip_0),
        .data_out (data_out_0),
        .valid_out(valid_out_0),
        .active   (active_0)
    );

    phy_rx_sync_lane #(
        .COM_CHAR    (COM_CHAR),
        .IDLE_CHAR   (IDLE_CHAR),
        .COM_COUNT   (COM_COUNT),
        .SLIP_TIMEOUT(SLIP_TIMEOUT),
        .SLIP_HOLDOFF(SLIP_HOLDOFF)
    ) lane_1 (
        .clk_f    (clk_f),
        .reset    (reset),
        .resync   (resync),
        .byte_in  (byte_in_1),
        .byte_vld (byte_vld_1),
        .gate_ok  (gate_ok),
        .lock_now (lock_now_1),
        .payload  (payload_1),
        .bit_slip (bit_slip_1),
        .data_out (data_out_1),
        .valid_out(valid_out_1),
        .active   (active_1)
    );

    always_ff @(posedge clk_f) begin
        if (reset) begin
            all_active <= 1'b0;
        end else begin
            all_active <= all_next;
        end
    end
endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Self-checking bench for phy_rx_sync_ctrl: vector table, directed corner sequences, random vs reference model.
// Expectations follow PHY_RX_LANE_GATE_EN when it is defined for the build.

module tb_phy_rx_sync_ctrl;
    localparam logic [7:0] COM          = 8'hBC;
    localparam logic [7:0] IDLE         = 8'h7C;
    localparam int         COM_COUNT    = 4;
    localparam int         SLIP_TIMEOUT = 8;
    localparam int         SLIP_HOLDOFF = 2;
`ifdef PHY_RX_LANE_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic       clk_f = 1'b0;
    logic       reset;
    logic       resync;
    logic [7:0] byte_in_0;
    logic       byte_vld_0;
    logic [7:0] byte_in_1;
    logic       byte_vld_1;
    logic       bit_slip_0;
    logic       bit_slip_1;
    logic [7:0] data_out_0;
    logic       valid_out_0;
    logic [7:0] data_out_1;
    logic       valid_out_1;
    logic       active_0;
    logic       active_1;
    logic       all_active;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_f = ~clk_f;

    phy_rx_sync_ctrl dut (
        .clk_f      (clk_f),
        .reset      (reset),
        .byte_in_0  (byte_in_0),
        .byte_vld_0 (byte_vld_0),
        .byte_in_1  (byte_in_1),
        .byte_vld_1 (byte_vld_1),
        .resync     (resync),
        .bit_slip_0 (bit_slip_0),
        .bit_slip_1 (bit_slip_1),
        .data_out_0 (data_out_0),
        .valid_out_0(valid_out_0),
        .data_out_1 (data_out_1),
        .valid_out_1(valid_out_1),
        .active_0   (active_0),
        .active_1   (active_1),
        .all_active (all_active)
    );

    // Reference model: each lane is described by whether it is locked, how long its comma run is,
    // how many misses it has seen and how many bytes it still has to ignore after a slip.
    bit         m_locked [2];
    int         m_run    [2];
    int         m_miss   [2];
    int         m_settle [2];
    logic [7:0] m_data   [2];
    bit         m_valid  [2];
    bit         m_slip   [2];
    bit         m_all;

    typedef struct {
        logic        rst;
        logic        rs;
        logic [7:0]  b0;
        logic        v0;
        logic [7:0]  b1;
        logic        v1;
        logic [22:0] exp;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] broken_seq [7];

    function automatic logic [22:0] mkExp(input logic s0, input logic s1, input logic v0, input logic [7:0] d0,
                                          input logic v1, input logic [7:0] d1, input logic a0, input logic a1,
                                          input logic al);
        return {s0, s1, v0, d0, v1, d1, a0, a1, al};
    endfunction

    function automatic logic [22:0] dutVec();
        return {bit_slip_0, bit_slip_1, valid_out_0, data_out_0, valid_out_1, data_out_1,
                active_0, active_1, all_active};
    endfunction

    function automatic logic [22:0] modelVec();
        return mkExp(m_slip[0], m_slip[1], m_valid[0], m_data[0], m_valid[1], m_data[1],
                     m_locked[0], m_locked[1], m_all);
    endfunction

    task automatic modelStep(input logic rst, input logic rs, input logic [7:0] b0, input logic v0,
                             input logic [7:0] b1, input logic v1);
        logic [7:0] lb  [2];
        logic       lv  [2];
        bit         fwd [2];
        lb[0] = b0; lb[1] = b1;
        lv[0] = v0; lv[1] = v1;
        for (int l = 0; l < 2; l++) begin
            fwd[l]    = 1'b0;
            m_slip[l] = 1'b0;
            m_valid[l] = 1'b0;
            if (rst || rs) begin
                m_locked[l] = 1'b0;
                m_run[l]    = 0;
                m_miss[l]   = 0;
                m_settle[l] = 0;
                if (rst) m_data[l] = 8'h00;
            end else if (lv[l]) begin
                if (m_locked[l]) begin
                    fwd[l] = (lb[l] != COM) && (lb[l] != IDLE);
                end else if (m_run[l] > 0) begin
                    if (lb[l] == COM) begin
                        m_run[l] = m_run[l] + 1;
                        if (m_run[l] == COM_COUNT) m_locked[l] = 1'b1;
                    end else begin
                        m_run[l]  = 0;
                        m_miss[l] = 0;
                    end
                end else if (m_settle[l] > 0) begin
                    m_settle[l] = m_settle[l] - 1;
                end else if (lb[l] == COM) begin
                    m_run[l] = 1;
                end else begin
                    m_miss[l] = m_miss[l] + 1;
                    if (m_miss[l] == SLIP_TIMEOUT) begin
                        m_slip[l]   = 1'b1;
                        m_miss[l]   = 0;
                        m_settle[l] = SLIP_HOLDOFF;
                    end
                end
            end
        end
        m_all = m_locked[0] && m_locked[1];
        for (int l = 0; l < 2; l++) begin
            if (fwd[l] && (!GATE || m_all)) begin
                m_valid[l] = 1'b1;
                m_data[l]  = lb[l];
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [22:0] actual, input logic [22:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rs, input logic [7:0] b0, input logic v0,
                                 input logic [7:0] b1, input logic v1);
        reset      = rst;
        resync     = rs;
        byte_in_0  = b0;
        byte_vld_0 = v0;
        byte_in_1  = b1;
        byte_vld_1 = v1;
        modelStep(rst, rs, b0, v0, b1, v1);
        @(posedge clk_f);
        #1;
        checkOutput("model", dutVec(), modelVec());
    endtask

    function automatic logic [7:0] pickByte(input bit burst);
        int r;
        r = $urandom_range(0, 99);
        if (r < (burst ? 85 : 20)) return COM;
        if (r < (burst ? 92 : 30)) return IDLE;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        bit         burst0;
        bit         burst1;
        logic       r_rst;
        logic       r_rs;
        logic       r_v0;
        logic       r_v1;
        logic [7:0] r_b0;
        logic [7:0] r_b1;

        reset = 1'b1; resync = 1'b0;
        byte_in_0 = 8'h00; byte_vld_0 = 1'b0; byte_in_1 = 8'h00; byte_vld_1 = 1'b0;

        // Lock on both lanes, then payload with an embedded idle.
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mkExp(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0)};
        vecs[1] = '{1'b0, 1'b0, COM,   1'b1, COM,   1'b1, mkExp(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0)};
        vecs[2] = '{1'b0, 1'b0, COM,   1'b1, COM,   1'b1, mkExp(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0)};
        vecs[3] = '{1'b0, 1'b0, COM,   1'b1, COM,   1'b1, mkExp(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0)};
        vecs[4] = '{1'b0, 1'b0, COM,   1'b1, COM,   1'b1, mkExp(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 1)};
        vecs[5] = '{1'b0, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b1, mkExp(0, 0, 1, 8'h5A, 1, 8'h5A, 1, 1, 1)};
        vecs[6] = '{1'b0, 1'b0, IDLE,  1'b1, IDLE,  1'b1, mkExp(0, 0, 0, 8'h5A, 0, 8'h5A, 1, 1, 1)};
        vecs[7] = '{1'b0, 1'b0, 8'h33, 1'b1, 8'h33, 1'b1, mkExp(0, 0, 1, 8'h33, 1, 8'h33, 1, 1, 1)};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mkExp(0, 0, 0, 8'h33, 0, 8'h33, 1, 1, 1)};
        broken_seq = '{COM, COM, 8'h11, COM, COM, COM, COM};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].rs, vecs[i].b0, vecs[i].v0, vecs[i].b1, vecs[i].v1);
            checkOutput($sformatf("table[%0d]", i), dutVec(), vecs[i].exp);
        end

        // Slip on lane 0: eight misses, one-cycle pulse, two ignored bytes, then lock.
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
        for (int k = 0; k < SLIP_TIMEOUT; k++) begin
            applyStimulus(0, 0, 8'h00, 1, 8'h00, 0);
            checkOutput($sformatf("slip_byte%0d", k), bit_slip_0, (k == SLIP_TIMEOUT - 1));
        end
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);
        checkOutput("slip_one_cycle", bit_slip_0, 1'b0);
        for (int k = 0; k < SLIP_HOLDOFF; k++) begin
            applyStimulus(0, 0, COM, 1, 8'h00, 0);
            checkOutput("slip_holdoff_active", active_0, 1'b0);
        end
        for (int k = 0; k < COM_COUNT; k++) begin
            applyStimulus(0, 0, COM, 1, 8'h00, 0);
            checkOutput($sformatf("slip_lock%0d", k), active_0, (k == COM_COUNT - 1));
        end

        // Broken lock: a stray byte restarts the comma count without slipping.
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 0, broken_seq[k], 1, 8'h00, 0);
            checkOutput($sformatf("broken_active%0d", k), active_0, (k == 6));
            checkOutput($sformatf("broken_noslip%0d", k), bit_slip_0, 1'b0);
        end

        // Skew: lane 0 locks first and carries payload 0xA1 before lane 1 is locked.
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
        applyStimulus(0, 0, COM, 1, 8'h00, 0);
        applyStimulus(0, 0, COM, 1, 8'h00, 0);
        applyStimulus(0, 0, COM, 1, 8'h00, 0);
        applyStimulus(0, 0, COM, 1, COM, 1);
        checkOutput("skew_lane0_locked", {active_0, active_1, all_active}, 3'b100);
        applyStimulus(0, 0, 8'hA1, 1, COM, 1);
        checkOutput("skew_valid0", valid_out_0, !GATE);
        checkOutput("skew_data0", data_out_0, GATE ? 8'h00 : 8'hA1);
        applyStimulus(0, 0, 8'h00, 0, COM, 1);
        applyStimulus(0, 0, 8'h00, 0, COM, 1);
        checkOutput("skew_all_active", {active_0, active_1, all_active, valid_out_0}, 4'b1110);
        applyStimulus(0, 0, 8'hA2, 1, 8'h00, 0);
        checkOutput("skew_after_both", {valid_out_0, data_out_0}, {1'b1, 8'hA2});

        // resync wins over a same-cycle byte, then reset in the middle of LOCKING.
        applyStimulus(0, 1, 8'h55, 1, 8'h66, 1);
        checkOutput("resync_drop", dutVec(), mkExp(0, 0, 0, 8'hA2, 0, 8'h00, 0, 0, 0));
        applyStimulus(0, 0, COM, 1, COM, 1);
        applyStimulus(0, 0, COM, 1, COM, 1);
        applyStimulus(1, 1, COM, 1, COM, 1);
        checkOutput("reset_mid_locking", dutVec(), 23'h0);

        // Random traffic against the reference model, with bursts of commas so lanes do lock.
        burst0 = 1'b0;
        burst1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                burst0 = ($urandom_range(0, 99) < 60);
                burst1 = ($urandom_range(0, 99) < 60);
            end
            r_rst = ($urandom_range(0, 599) == 0);
            r_rs  = ($urandom_range(0, 249) == 0);
            r_v0  = ($urandom_range(0, 9) < 8);
            r_v1  = ($urandom_range(0, 9) < 8);
            r_b0  = pickByte(burst0);
            r_b1  = pickByte(burst1);
            applyStimulus(r_rst, r_rs, r_b0, r_v0, r_b1, r_v1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/phy_rx_sync_ctrl.md
Name: phy_rx_sync_ctrl

Overview:
Per-lane symbol-lock controller for the two-lane PHY receiver. It sits after the two serial-to-parallel deserializers in the clk_f byte domain. It watches each lane's byte stream for the 0xBC comma and commands bit-slip realignment when no comma is found. Once a lane holds lock it releases that lane's payload bytes to the link layer and strips comma and idle characters.

Parameters:
COM_CHAR, 8'hBC, comma/alignment character.
IDLE_CHAR, 8'h7C, idle filler character; never forwarded as payload.
COM_COUNT, 4, consecutive commas required to declare lock (range 2..15).
SLIP_TIMEOUT, 8, valid non-comma bytes in SEARCH before a bit_slip pulse (range 2..255).
SLIP_HOLDOFF, 2, valid bytes ignored after a bit_slip while the deserializer settles.

Ports:
clk_f  in  1  byte-rate clock; the only clock of the block.
reset  in  1  synchronous, active-high reset.
byte_in_0  in  8  lane 0 deserialized byte.
byte_vld_0  in  1  lane 0 byte strobe.
byte_in_1  in  8  lane 1 deserialized byte.
byte_vld_1  in  1  lane 1 byte strobe.
resync  in  1  one-cycle request forcing both lanes back to SEARCH.
bit_slip_0  out  1  one-cycle pulse; lane 0 deserializer shifts its alignment by 1 bit.
bit_slip_1  out  1  same for lane 1.
data_out_0  out  8  lane 0 payload byte, registered.
valid_out_0  out  1  lane 0 payload strobe.
data_out_1  out  8  lane 1 payload byte, registered.
valid_out_1  out  1  lane 1 payload strobe.
active_0  out  1  lane 0 locked.
active_1  out  1  lane 1 locked.
all_active  out  1  active_0 & active_1, registered.

Behaviour:
- Reset: reset=1 at a posedge clk_f clears all outputs to 0 next cycle, including data_out_x=8'h00. Both FSMs go to SEARCH and all counters clear. Reset applied mid-operation behaves identically and any pending slip is dropped.
- The two lanes run identical, fully independent FSMs with states SEARCH, LOCKING, ACTIVE. Only strobed bytes (byte_vld_x=1) advance an FSM.
- SEARCH:
  - While holdoff_cnt>0, each valid byte only decrements holdoff_cnt.
  - Otherwise, a COM byte sets com_cnt=1 and moves the FSM to LOCKING.
  - Any other byte increments miss_cnt. The byte that brings miss_cnt to SLIP_TIMEOUT pulses bit_slip_x high for exactly 1 cycle, the cycle after that byte. It also clears miss_cnt and loads holdoff_cnt=SLIP_HOLDOFF.
- LOCKING:
  - A COM byte increments com_cnt. When com_cnt reaches COM_COUNT, the FSM moves to ACTIVE and active_x=1 the next cycle.
  - A non-COM byte returns the FSM to SEARCH with com_cnt=0 and miss_cnt=0. No slip is issued.
- ACTIVE:
  - A byte that is neither COM_CHAR nor IDLE_CHAR is forwarded: data_out_x equals that byte and valid_out_x=1, one cycle after the strobe (latency 1).
  - COM and IDLE bytes give valid_out_x=0, and data_out_x holds its last value.
  - ACTIVE persists until reset or resync.
- The byte that completes lock is a COM and is never forwarded. The first payload byte is the first non-COM/IDLE byte after lock.
- resync=1: both FSMs go to SEARCH and active_x, valid_out_x and all_active drop the next cycle. resync takes precedence over a byte_vld arriving in the same cycle; that byte is discarded. reset takes precedence over resync.
- bit_slip_x is never asserted in LOCKING or ACTIVE. It never appears on two consecutive cycles.
- Counters saturate and never wrap.

Optional Feature:
PHY_RX_LANE_GATE_EN.
- Defined: valid_out_0 and valid_out_1 are additionally ANDed with all_active. Payload from a lane that locked first is discarded until the other lane locks, so the link layer never sees single-lane data.
- Undefined: each lane forwards payload as soon as its own active_x=1. all_active is informational only.

Test Plan:
- Lock: both lanes get BC,BC,BC,BC, then 0x5A, 0x7C, 0x33. Required: active_x=1 the cycle after the 4th BC; valid_out_x pulses with 0x5A then 0x33; no valid for 0x7C; bit_slip never pulses.
- Slip: lane 0 gets 8 bytes of 0x00. Required: bit_slip_0=1 for 1 cycle after the 8th byte; the next 2 bytes are ignored; then BC x4 reaches ACTIVE.
- Broken lock: BC,BC,0x11,BC,BC,BC,BC. Required: FSM back in SEARCH after 0x11; active=1 only after the final BC; no slip.
- Skew with macro on: lane 0 locks 3 bytes before lane 1 while payload 0xA1 arrives on lane 0. Required: no valid_out_0 until all_active=1. With macro off, valid_out_0 shows 0xA1.
- resync and byte_vld in the same cycle while ACTIVE. Required: all active/valid outputs at 0 the next cycle and the byte dropped. Then reset asserted mid-LOCKING: all outputs at 0 the next cycle.
